// File: rtl/tube_scan_controller_pkg.sv
// Shared constants and types for the 8-digit tube refresh scheduler.
package tube_scan_controller_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] BLANK_SHAPE = 8'hFF;
  localparam logic [7:0] ALL_OFF = 8'hFF;

  // Active-high gfedcba patterns, indexed by the hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0100111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   digit_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    zero_blank;
  } tube_cfg_t;

endpackage

// File: rtl/tube_scan_controller_hex_to_seg7.sv
// Hex nibble to active-high gfedcba segment pattern.
module hex_to_seg7
  import tube_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/tube_scan_controller.sv
// Time-multiplexed refresh of the 8-digit tube with dead-time blanking,
// blinking, leading-zero suppression and frame-aligned config updates.
module tube_scan_controller
  import tube_scan_controller_pkg::*;
#(
  parameter int SCAN_DIV       = 40000,
  parameter int BLANK_CYCLES   = 2000,
  parameter int BLINK_DIV_LOG2 = 24
) (
  input  logic                    iFpgaClock,
  input  logic                    iCpuReset,
  input  logic [4*NUM_DIGITS-1:0] iDisplayData,
  input  logic [NUM_DIGITS-1:0]   iDigitMask,
  input  logic [NUM_DIGITS-1:0]   iBlinkMask,
  input  logic [NUM_DIGITS-1:0]   iDecimalPoint,
  input  logic                    iZeroBlank,
  input  logic                    iConfigLoad,
  output logic [NUM_DIGITS-1:0]   oDigitalTubeNotEnable,
  output logic [7:0]              oDigitalTubeShape,
  output logic                    oFrameStart,
  output logic                    oConfigBusy
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          slot_cnt_reg;
  logic [IDX_W-1:0]          digit_idx_reg;
  logic [BLINK_DIV_LOG2-1:0] blink_cnt_reg;
  logic                      pending_reg;
  tube_cfg_t                 active_cfg_reg;
  tube_cfg_t                 staging_cfg_reg;
  tube_cfg_t                 load_cfg;

  logic                  frame_end;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg;
  logic                  zero_blanked;
  logic                  visible;
  logic [NUM_DIGITS-1:0] not_enable_next;
  logic [7:0]            shape_next;
  logic                  frame_start_next;

  always_comb begin
    load_cfg            = '0;
    load_cfg.data       = iDisplayData;
    load_cfg.digit_mask = iDigitMask;
    load_cfg.blink_mask = iBlinkMask;
    load_cfg.dp         = iDecimalPoint;
    load_cfg.zero_blank = iZeroBlank;
  end

  assign frame_end = (slot_cnt_reg == SLOT_LAST) && (digit_idx_reg == IDX_LAST);

  always_ff @(posedge iFpgaClock) begin
    if (iCpuReset) begin
      slot_cnt_reg    <= '0;
      digit_idx_reg   <= '0;
      blink_cnt_reg   <= '0;
      pending_reg     <= 1'b0;
      active_cfg_reg  <= '0;
      staging_cfg_reg <= '0;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
      if (slot_cnt_reg == SLOT_LAST) begin
        slot_cnt_reg  <= '0;
        digit_idx_reg <= digit_idx_reg + 1'b1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
      // Active config only ever changes on the frame boundary.
      if (iConfigLoad) begin
        staging_cfg_reg <= load_cfg;
        if (frame_end) begin
          active_cfg_reg <= load_cfg;
          pending_reg    <= 1'b0;
        end else begin
          pending_reg <= 1'b1;
        end
      end else if (frame_end) begin
        if (pending_reg) active_cfg_reg <= staging_cfg_reg;
        pending_reg <= 1'b0;
      end
    end
  end

  // zero_from[i]: nibbles i..7 of the active image are all zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign zero_from[gi] = (active_cfg_reg.data[4*NUM_DIGITS-1:4*gi] == '0);
    end
  endgenerate

  assign cur_nibble = active_cfg_reg.data[{digit_idx_reg, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  assign zero_blanked = active_cfg_reg.zero_blank && (digit_idx_reg != '0)
                        && zero_from[digit_idx_reg];
  assign visible = (slot_cnt_reg >= BLANK_END)
                   && active_cfg_reg.digit_mask[digit_idx_reg]
                   && !(active_cfg_reg.blink_mask[digit_idx_reg]
                        && blink_cnt_reg[BLINK_DIV_LOG2-1])
                   && !zero_blanked;

  always_comb begin
    not_enable_next = ALL_OFF;
    shape_next      = BLANK_SHAPE;
    if (visible) begin
      not_enable_next = ~(NUM_DIGITS'(1) << digit_idx_reg);
      shape_next      = {~active_cfg_reg.dp[digit_idx_reg], ~cur_seg};
    end
  end

  assign frame_start_next = (slot_cnt_reg == '0) && (digit_idx_reg == '0);

  always_ff @(posedge iFpgaClock) begin
    if (iCpuReset) begin
      oDigitalTubeNotEnable <= ALL_OFF;
      oDigitalTubeShape     <= BLANK_SHAPE;
      oFrameStart           <= 1'b0;
      oConfigBusy           <= 1'b0;
    end else begin
      oDigitalTubeNotEnable <= not_enable_next;
      oDigitalTubeShape     <= shape_next;
      oFrameStart           <= frame_start_next;
      oConfigBusy           <= pending_reg;
    end
  end

endmodule
